// File: rtl/sd_stream_gen_pkg.sv
// Shared types and constants for the srdy/drdy stream generator.
// Holds the FSM state encoding and the maximal-length Galois LFSR taps per data width.
package sd_stream_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] t;
        case (w)
            32'sd8:  t = TAPS_8;
            32'sd16: t = TAPS_16;
            32'sd32: t = TAPS_32;
            default: t = TAPS_8;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sd_lfsr_step.sv
// Combinational single step of a right-shifting Galois LFSR.
// Taps are chosen from the package for the configured width.
module sd_lfsr_step
    import sd_stream_gen_pkg::*;
#(
    parameter int width = 8
) (
    input  logic [width-1:0] cur,
    output logic [width-1:0] nxt
);

    localparam logic [31:0]      TAPS_ALL = lfsr_taps(width);
    localparam logic [width-1:0] TAPS_W   = TAPS_ALL[width-1:0];

    // shift right and fold the taps back in when a one drops out
    always_comb begin
        nxt = {1'b0, cur[width-1:1]};
        if (cur[0]) begin
            nxt = {1'b0, cur[width-1:1]} ^ TAPS_W;
        end else begin
            nxt = {1'b0, cur[width-1:1]};
        end
    end

endmodule

// File: rtl/sd_stream_gen.sv
// srdy/drdy producer: emits a programmed number of words with an idle gap after each.
// Define SD_STREAM_GEN_LFSR_EN to produce LFSR data instead of incrementing data.
module sd_stream_gen
    import sd_stream_gen_pkg::*;
#(
    parameter int width  = 8,
    parameter int cnt_sz = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [cnt_sz-1:0] count,
    input  logic [3:0]        gap,
    input  logic [width-1:0]  seed,
    output logic              p_srdy,
    input  logic              p_drdy,
    output logic [width-1:0]  p_data,
    output logic              busy,
    output logic              done,
    output logic [cnt_sz-1:0] sent
);

    localparam logic [cnt_sz-1:0] CNT_ZERO = {cnt_sz{1'b0}};
    localparam logic [cnt_sz-1:0] CNT_ONE  = {{(cnt_sz-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            next_state_s;
    logic [cnt_sz-1:0] count_r;
    logic [cnt_sz-1:0] sent_r;
    logic [cnt_sz-1:0] sent_inc_s;
    logic [3:0]        gap_r;
    logic [3:0]        gap_cnt_r;
    logic [width-1:0]  data_r;
    logic [width-1:0]  data_next_s;
    logic [width-1:0]  seed_load_s;
    logic              xfer_s;
    logic              p_srdy_s;
    logic              busy_s;
    logic              done_s;
    logic              p_srdy_r;
    logic              busy_r;
    logic              done_r;

`ifdef SD_STREAM_GEN_LFSR_EN
    sd_lfsr_step #(.width(width)) u_lfsr_step (
        .cur (data_r),
        .nxt (data_next_s)
    );

    // a zero seed would lock the LFSR, so it is promoted to one
    always_comb begin
        if (seed == {width{1'b0}}) begin
            seed_load_s = {{(width-1){1'b0}}, 1'b1};
        end else begin
            seed_load_s = seed;
        end
    end
`else
    // incrementing data source, wraps modulo 2^width
    always_comb begin
        data_next_s = data_r + {{(width-1){1'b0}}, 1'b1};
        seed_load_s = seed;
    end
`endif

    assign xfer_s     = (state_r == ST_SEND) && p_drdy;
    assign sent_inc_s = sent_r + CNT_ONE;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = (count == CNT_ZERO) ? ST_DONE : ST_SEND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!xfer_s) begin
                    next_state_s = ST_SEND;
                end else if (sent_inc_s == count_r) begin
                    next_state_s = ST_DONE;
                end else if (gap_r != 4'd0) begin
                    next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r <= 4'd1) begin
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // outputs decoded from the next state so they can be registered alongside it
    always_comb begin
        p_srdy_s = 1'b0;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        case (next_state_s)
            ST_IDLE: begin
                p_srdy_s = 1'b0;
                busy_s   = 1'b0;
                done_s   = 1'b0;
            end
            ST_SEND: begin
                p_srdy_s = 1'b1;
                busy_s   = 1'b1;
                done_s   = 1'b0;
            end
            ST_GAP: begin
                p_srdy_s = 1'b0;
                busy_s   = 1'b1;
                done_s   = 1'b0;
            end
            ST_DONE: begin
                p_srdy_s = 1'b0;
                busy_s   = 1'b1;
                done_s   = 1'b1;
            end
            default: begin
                p_srdy_s = 1'b0;
                busy_s   = 1'b0;
                done_s   = 1'b0;
            end
        endcase
    end

    // registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            p_srdy_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            p_srdy_r <= p_srdy_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    // datapath: latched parameters, data word, transfer and gap counters
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r   <= CNT_ZERO;
            sent_r    <= CNT_ZERO;
            gap_r     <= 4'd0;
            gap_cnt_r <= 4'd0;
            data_r    <= {width{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        sent_r <= CNT_ZERO;
                        if (count != CNT_ZERO) begin
                            count_r <= count;
                            gap_r   <= gap;
                            data_r  <= seed_load_s;
                        end
                    end
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        sent_r    <= sent_inc_s;
                        data_r    <= data_next_s;
                        gap_cnt_r <= gap_r;
                    end
                end
                ST_GAP: begin
                    gap_cnt_r <= gap_cnt_r - 4'd1;
                end
                default: begin
                    gap_cnt_r <= gap_cnt_r;
                end
            endcase
        end
    end

    assign p_srdy = p_srdy_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign sent   = sent_r;
    assign p_data = data_r;

endmodule
